// File: rtl/trivium_prng_stream.sv
// Trivium keystream generator feeding masking randomness to DOM datapaths.
// Each state update advances the cipher by W serial steps; the words land in
// a small FIFO exposed as a valid/ready stream. A seed handshake reloads
// key/IV, flushes buffered words and reruns the warm-up phase.
module trivium_prng_stream #(
  parameter int W          = 64,
  parameter int INIT_BITS  = 1152,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          seed_valid,
  output logic          seed_ready,
  input  logic [79:0]   key,
  input  logic [79:0]   iv,
  output logic          rnd_valid,
  input  logic          rnd_ready,
  output logic [W-1:0]  rnd_data,
  output logic          running
);

  localparam int INIT_STEPS = INIT_BITS / W;
  localparam int STEP_CW    = (INIT_STEPS > 1) ? $clog2(INIT_STEPS) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [STEP_CW-1:0] INIT_LAST = STEP_CW'(INIT_STEPS - 1);
  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(FIFO_DEPTH);

  // Reject illegal parameterisations at elaboration time.
  if (W < 1 || W > 64) begin : g_bad_w
    $error("trivium_prng_stream: W must be in 1..64");
  end
  if ((INIT_BITS % W) != 0 || INIT_BITS < W) begin : g_bad_init
    $error("trivium_prng_stream: INIT_BITS must be a nonzero multiple of W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trivium_prng_stream: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [W-1:0] z;
    logic [287:0] s;
  } step_t;

  // W serial Trivium updates. s_i lives at S[288-i], so each register shifts
  // towards lower S indices and the feedback enters at s1, s94 and s178.
  function automatic step_t triv_step(input logic [287:0] s_in);
    step_t        r;
    logic [287:0] s;
    logic         t1;
    logic         t2;
    logic         t3;
    s   = s_in;
    r.z = {W{1'b0}};
    for (int j = 0; j < W; j++) begin
      t1     = s[222] ^ s[195];                 // s66 ^ s93
      t2     = s[126] ^ s[111];                 // s162 ^ s177
      t3     = s[45]  ^ s[0];                   // s243 ^ s288
      r.z[j] = t1 ^ t2 ^ t3;
      t1     = t1 ^ (s[197] & s[196]) ^ s[117]; // s91&s92 ^ s171
      t2     = t2 ^ (s[113] & s[112]) ^ s[24];  // s175&s176 ^ s264
      t3     = t3 ^ (s[2] & s[1]) ^ s[219];     // s286&s287 ^ s69
      s      = {t3, s[287:196], t1, s[194:112], t2, s[110:1]};
    end
    r.s = s;
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [287:0]       s_q, s_d;
  logic [STEP_CW-1:0] step_cnt_q, step_cnt_d;
  logic [W-1:0]       mem_q [FIFO_DEPTH];
  logic [W-1:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;

  step_t        step_s;
  logic [287:0] seed_state_s;
  logic         pop_s;
  logic         push_s;
  logic         seed_fire_s;

  assign step_s       = triv_step(s_q);
  assign seed_state_s = {key, 13'd0, iv, 4'd0, 111'd7};
  assign seed_fire_s  = seed_valid && (state_q != ST_INIT);
  assign pop_s        = (fifo_cnt_q != {CNT_W{1'b0}}) && rnd_ready;

  assign rnd_valid  = (fifo_cnt_q != {CNT_W{1'b0}});
  assign rnd_data   = rnd_valid ? mem_q[rd_ptr_q] : {W{1'b0}};
  assign seed_ready = (state_q != ST_INIT);
  assign running    = (state_q == ST_RUN);

  // Next-state logic: seeding, warm-up stepping and FIFO push/pop bookkeeping.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    step_cnt_d = step_cnt_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    push_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seed_fire_s) begin
          s_d        = seed_state_s;
          step_cnt_d = {STEP_CW{1'b0}};
          state_d    = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        s_d        = step_s.s;
        step_cnt_d = step_cnt_q + STEP_CW'(1'b1);
        if (step_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (seed_fire_s) begin
          // A same-cycle pop is simply absorbed by the flush.
          s_d        = seed_state_s;
          step_cnt_d = {STEP_CW{1'b0}};
          wr_ptr_d   = {PTR_W{1'b0}};
          rd_ptr_d   = {PTR_W{1'b0}};
          fifo_cnt_d = {CNT_W{1'b0}};
          state_d    = ST_INIT;
        end else begin
          // Step only when the produced word has a slot after this pop.
          push_s = (fifo_cnt_q < DEPTH_C) || pop_s;
          if (push_s) begin
            s_d             = step_s.s;
            mem_d[wr_ptr_q] = step_s.z;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
          end else begin
            s_d = s_q;
          end
          if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
          if (push_s && !pop_s) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1'b1);
          end else if (pop_s && !push_s) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1'b1);
          end else begin
            fifo_cnt_d = fifo_cnt_q;
          end
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, cipher and FIFO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      s_q        <= 288'd0;
      step_cnt_q <= {STEP_CW{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      fifo_cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      step_cnt_q <= step_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: doc/trivium_prng_stream.md
Name: trivium_prng_stream

Overview:
- Parametrised Trivium keystream generator that supplies fresh masking randomness to DOM-protected datapaths.
- Output width per step, init length and buffering depth are parameters.
- Output is a valid/ready stream from a small FIFO, so consumers can stall without losing or repeating bits.
- Reseed uses a valid/ready handshake that flushes buffered randomness.

Parameters:
- W, 64, keystream bits produced per state update; legal 1..64.
- INIT_BITS, 1152, warm-up bits discarded after seeding; must be a multiple of W (elaboration error otherwise).
- FIFO_DEPTH, 4, output buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- seed_valid  in  1  key/IV offered.
- seed_ready  out  1  seed can be accepted this cycle.
- key  in  80  Trivium key.
- iv  in  80  Trivium IV.
- rnd_valid  out  1  rnd_data holds an unconsumed word.
- rnd_ready  in  1  consumer takes rnd_data this cycle.
- rnd_data  out  W  keystream word; bit 0 is the earliest generated bit.
- running  out  1  high in RUN state.

Behaviour:
- Reset is synchronous and active-high (RST=1 at a clk edge).
- Reset sets state=IDLE, S[287:0]=0, step counter=0, FIFO empty.
- Reset values as seen the cycle after reset: rnd_valid=0, rnd_data=0, running=0, seed_ready=1.
- Reset during INIT or RUN aborts the operation and discards FIFO contents.
- State register mapping: s_i = S[288-i] for i=1..288.
- Seed load on the seed handshake:
  - S[287:208]=key, S[207:195]=0, S[194:115]=iv, S[114:111]=0, S[110:0]=111'd7 (s286..s288=1).
- One step = W consecutive serial Trivium updates, computed combinationally and registered in one cycle.
- Serial update:
  - t1=s66^s93, t2=s162^s177, t3=s243^s288; z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - Shift each register by one: s1<-t3, s94<-t1, s178<-t2.
- The j-th serial bit of a step (j=0 first) goes to word bit j.
- FSM:
  - IDLE: seed_ready=1. Seed handshake -> load S, counter=0, -> INIT.
  - INIT: seed_ready=0, one step per cycle, keystream discarded, counter++. At counter==INIT_BITS/W-1 the last step executes -> RUN.
  - RUN: seed_ready=1, running=1. A step executes in a cycle iff the FIFO has room after this cycle's pop (count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop). Each step pushes its z word.
- Latency (W=64, INIT_BITS=1152):
  - Seed accepted at edge T; init steps at edges T+1..T+18.
  - First push at edge T+19; rnd_valid=1 from that cycle on.
- FIFO behaviour:
  - rnd_data=head entry; rnd_data=0 while empty.
  - A pop occurs iff rnd_valid&rnd_ready.
  - Push and pop in the same cycle keep count; a sustained rate of one word per cycle is required when the consumer is always ready.
  - rnd_ready while empty is ignored.
  - Full with no pop: the state holds, no step executes.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Reseed in RUN (seed handshake):
  - A pop in the same cycle completes normally (the word counts as consumed).
  - The FIFO is then flushed, S reloaded, -> INIT.
  - rnd_valid=0 from the next cycle until the first post-init push.
- Seed inputs are sampled only at the handshake; changes at other times have no effect.
- No bit may ever be delivered twice, and no generated RUN bit may be dropped except by flush or reset.

Test Plan:
- Reset, then hold RST=1 for 3 cycles mid-INIT -> rnd_valid=0, running=0, seed_ready=1 after release; the following seed gives a full 18-step init.
- W=64, key=0, iv=0, rnd_ready=1 -> first rnd_valid exactly 19 cycles after the seed handshake; 32 words match a bit-serial Trivium model (1152 bits discarded) bit-for-bit.
- W=8, W=1 and W=64 with the same key=80'h0123456789ABCDEF0123 and iv=80'hFEDCBA9876543210FEDC -> the concatenated streams (bit 0 first) are identical for the first 512 bits.
- rnd_ready=0 for 20 cycles after init (FIFO_DEPTH=4) -> exactly 4 words buffered, S frozen; release -> words continue without gap or repeat vs. model.
- Random rnd_ready toggling for 1000 cycles -> delivered stream equals the model; FIFO count never exceeds 4 or goes below 0.
- Reseed in RUN with FIFO full and rnd_ready=1 in the same cycle -> the head word is consumed; next cycle rnd_valid=0; first new word is model(new key/IV) word 0 after 18 init cycles.
